cic_decim_param: RTL

//  Parametrised N-stage CIC decimator for the baseband receive chain.

---
 rtl/cic_decim_param.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/cic_decim_param.sv
// -----------------------------------------------------------------------------
// cic_decim_param
//   N-stage CIC decimator with runtime-programmable rate and output shift.
//   The integrators are pipelined. The comb chain is combinational from the
//   last integrator and is evaluated once per output block. The output is a
//   saturated OUT_W-bit sample.
//
// Optional feature (compile-time macro):
//   CIC_ROUND_EN  : when defined, adds 2^(shift-1) before the arithmetic
//                   shift, which gives round-half-up. When undefined, the shift
//                   truncates toward -inf and no rounding adder is built.
//
// Ports:
//   clk         clock
//   syn_rst     synchronous active-high reset
//   clk_enable  input sample valid; filter_in is consumed when high
//   filter_in   signed input sample
//   cfg_load    one-cycle pulse: latch cfg_rate/cfg_shift, flush the datapath
//   cfg_rate    decimation rate, clamped to [2, R_MAX]
//   cfg_shift   right shift before saturation, clamped to ACC_W-OUT_W
//   filter_out  decimated sample; held between strobes
//   ce_out      one-cycle pulse marking a new filter_out
//   ovf_flag    sticky saturation indicator; cleared by syn_rst or cfg_load
// -----------------------------------------------------------------------------
module cic_decim_param #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int N     = 4,
    parameter int M     = 1,
    parameter int R_MAX = 64,
    localparam int R_W   = $clog2(R_MAX + 1),
    localparam int ACC_W = IN_W + N * $clog2(R_MAX * M)
) (
    input  logic                    clk,
    input  logic                    syn_rst,
    input  logic                    clk_enable,
    input  logic signed [IN_W-1:0]  filter_in,
    input  logic                    cfg_load,
    input  logic [R_W-1:0]          cfg_rate,
    input  logic [5:0]              cfg_shift,
    output logic signed [OUT_W-1:0] filter_out,
    output logic                    ce_out,
    output logic                    ovf_flag
);

    localparam int SH_MAX = ACC_W - OUT_W;
    localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W:0] OUT_MIN = (ACC_W+1)'(-(2**(OUT_W-1)));

    logic [R_W-1:0]          rate_q;
    logic [5:0]              shift_q;
    logic [R_W-1:0]          cnt_q;
    logic                    pend_q;   // comb/output evaluation due this cycle
    logic signed [ACC_W-1:0] integ_q [N];
    logic signed [ACC_W-1:0] dly_q   [N][M];

    logic [R_W-1:0]          rate_next;
    logic [5:0]              shift_next;
    logic                    dec_stb;
    logic signed [ACC_W-1:0] comb_in [N];
    logic signed [ACC_W-1:0] comb_out;
    logic signed [ACC_W:0]   y_ext;
    logic signed [ACC_W:0]   y_sh;
    logic [OUT_W-1:0]        y_sat;
    logic                    y_ovf;

    assign dec_stb = clk_enable && (cnt_q == rate_q - R_W'(1));

    // Clamp the configuration before it is latched.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first;
        // a path that leaves one unassigned would infer a latch.
        rate_next  = cfg_rate;
        shift_next = cfg_shift;
        if (cfg_rate < R_W'(2))
            rate_next = R_W'(2);
        else if (cfg_rate > R_W'(R_MAX))
            rate_next = R_W'(R_MAX);
        if (int'(cfg_shift) > SH_MAX)
            shift_next = 6'(SH_MAX);
    end

    // Comb chain. This is a blocking running difference from the last
    // integrator. comb_in[k] is the value that enters stage k's delay line.
    always_comb begin
        comb_out = integ_q[N-1];
        for (int k = 0; k < N; k++) begin
            comb_in[k] = comb_out;
            comb_out   = comb_out - dly_q[k][M-1];
        end
    end

    // Output stage: the value is extended by one bit so that the rounding
    // offset cannot wrap. It is then shifted and saturated.
    always_comb begin
        y_ext = {comb_out[ACC_W-1], comb_out};
`ifdef CIC_ROUND_EN
        if (shift_q != 6'd0)
            y_ext = y_ext + ((ACC_W+1)'(1) << (shift_q - 6'd1));
`endif
        y_sh  = y_ext >>> shift_q;
        y_ovf = 1'b0;
        if (y_sh > OUT_MAX) begin
            y_sat = OUT_MAX[OUT_W-1:0];
            y_ovf = 1'b1;
        end else if (y_sh < OUT_MIN) begin
            y_sat = OUT_MIN[OUT_W-1:0];
            y_ovf = 1'b1;
        end else begin
            y_sat = y_sh[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (syn_rst || cfg_load) begin
            // NOTE: the integrator and comb arrays are reset explicitly because
            // both reset and cfg_load must restart the filter from zero state.
            // These arrays are registers, not RAM.
            for (int k = 0; k < N; k++) begin
                integ_q[k] <= '0;
                for (int j = 0; j < M; j++)
                    dly_q[k][j] <= '0;
            end
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            filter_out <= '0;
            ce_out     <= 1'b0;
            ovf_flag   <= 1'b0;
            if (syn_rst) begin
                rate_q  <= R_W'(R_MAX);
                shift_q <= 6'd0;
            end else begin
                rate_q  <= rate_next;
                shift_q <= shift_next;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments. Because of
            // this, every integrator stage below adds the previous stage's old
            // value, which gives the pipelined structure.
            if (clk_enable) begin
                integ_q[0] <= integ_q[0] + {{(ACC_W-IN_W){filter_in[IN_W-1]}}, filter_in};
                for (int k = 1; k < N; k++)
                    integ_q[k] <= integ_q[k] + integ_q[k-1];
                cnt_q <= dec_stb ? '0 : cnt_q + R_W'(1);
            end

            pend_q <= dec_stb;
            ce_out <= pend_q;

            // The pending output completes even if clk_enable is low.
            if (pend_q) begin
                for (int k = 0; k < N; k++) begin
                    dly_q[k][0] <= comb_in[k];
                    for (int j = 1; j < M; j++)
                        dly_q[k][j] <= dly_q[k][j-1];
                end
                filter_out <= y_sat;
                if (y_ovf)
                    ovf_flag <= 1'b1;
            end
        end
    end

endmodule
